uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx serializer among NUM_REQ byte sources via round-robin arbitration with packet lock.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer among NUM_REQ byte sources.
// Arbitration is round-robin. A granted requester keeps the serializer for a whole
// packet, up to MAX_BURST bytes. Only one byte is in flight at a time, and the
// tx_busy handshake from uart_tx sequences the frames.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int START_TO  = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_busy,
    output logic                       tx_en,
    output logic [7:0]                 tx_din,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_active,
    output logic                       tx_err
);

    localparam int ID_W = $clog2(NUM_REQ);
    // The largest value to_cnt reaches is START_TO-2, so this width always fits it.
    localparam int TO_W = $clog2(START_TO);

    localparam logic [1:0] ST_ARB        = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    logic [1:0]           state;
    logic [ID_W-1:0]      rr_ptr;      // requester with top priority in the next unlocked search
    logic [7:0]           burst_cnt;   // bytes accepted under the current lock
    logic [TO_W-1:0]      to_cnt;      // cycles spent waiting for tx_busy to rise

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic [ID_W-1:0]      rr_winner;
    logic [ID_W-1:0]      cand;
    logic                 cand_valid;
    logic                 cand_last;
    logic [7:0]           cand_data;
    logic                 arb_open;
    logic                 xfer;
    logic                 lock_drop;
    logic [7:0]           new_cnt;
    logic                 rel_lock;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    // Round-robin search. The valid vector is rotated so that rr_ptr lands on bit 0,
    // and the lowest set bit of the rotated vector wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        valid_dbl = {req_valid, req_valid} >> rr_ptr;
        valid_rot = valid_dbl[NUM_REQ-1:0];
        rr_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                rr_winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Select the candidate (the lock holder if locked, otherwise the RR winner) and its byte fields.
    always_comb begin
        cand       = grant_active ? grant_id : rr_winner;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cand_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand == ID_W'(i)) begin
                cand_valid = req_valid[i];
                cand_last  = req_last[i];
                cand_data  = req_data[8*i +: 8];
            end
        end
    end

    // Handshake and lock bookkeeping for the current ARB cycle.
    // While reset is asserted no handshake is offered, so a producer never sees a phantom transfer.
    always_comb begin
        arb_open  = (state == ST_ARB) && !tx_busy && !sys_rst;
        xfer      = arb_open && cand_valid;
        lock_drop = arb_open && grant_active && !cand_valid;
        new_cnt   = grant_active ? burst_cnt + 8'd1 : 8'd1;
        rel_lock  = cand_last || (new_cnt == 8'(MAX_BURST));
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && (cand == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    assign tx_en = (state == ST_ISSUE);

    // Controller FSM, byte capture, lock and round-robin pointer updates.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments, so every register here sees values from before the edge.
        if (sys_rst) begin
            state        <= ST_ARB;
            tx_din       <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            tx_err       <= 1'b0;
            burst_cnt    <= '0;
            rr_ptr       <= '0;
            to_cnt       <= '0;
        end else begin
            tx_err <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (xfer) begin
                        tx_din       <= cand_data;
                        grant_id     <= cand;
                        burst_cnt    <= new_cnt;
                        grant_active <= !rel_lock;
                        if (rel_lock) begin
                            rr_ptr <= next_id(cand);
                        end
                        state <= ST_ISSUE;
                    end else if (lock_drop) begin
                        // The holder stopped offering bytes, so the lock is given up.
                        grant_active <= 1'b0;
                        rr_ptr       <= next_id(grant_id);
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (to_cnt == TO_W'(START_TO - 2)) begin
                        // tx_err is seen START_TO cycles after tx_en. The byte is dropped and the lock freed.
                        tx_err       <= 1'b1;
                        grant_active <= 1'b0;
                        rr_ptr       <= next_id(grant_id);
                        state        <= ST_ARB;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter.
// A behavioural uart_tx stub holds tx_busy for FRAME cycles after each tx_en.
// Per-requester byte lists stand in for the producers.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 3;
    localparam int START_TO  = 4;
    localparam int FRAME     = 6;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_busy;
    logic                 tx_en;
    logic [7:0]           tx_din;
    logic [1:0]           grant_id;
    logic                 grant_active;
    logic                 tx_err;

    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .START_TO(START_TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_busy(tx_busy), .tx_en(tx_en),
        .tx_din(tx_din), .grant_id(grant_id), .grant_active(grant_active), .tx_err(tx_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] src_mem [NUM_REQ][16];   // {last, data}
    int         src_len [NUM_REQ];
    int         src_pos [NUM_REQ];

    int  cyc         = 0;
    bit  stub_on     = 1'b1;
    int  busy_cnt    = 0;
    int  multi_ready = 0;
    int         acc_id[$];
    int         acc_cyc[$];
    logic [7:0] acc_data[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         err_cyc[$];

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_mem[i][src_pos[i]][7:0];
                req_last[i]        = src_mem[i][src_pos[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    function automatic bit drained();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_pos[i] < src_len[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic put(input int i, input logic [7:0] d, input bit last);
        src_mem[i][src_len[i]] = {last, d};
        src_len[i]++;
    endtask

    task automatic clear_all();
        acc_id.delete(); acc_cyc.delete(); acc_data.delete();
        tx_log.delete(); tx_cyc.delete(); err_cyc.delete();
        multi_ready = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while (!drained() && n < budget) begin
            @(posedge sys_clk); #3;
            n++;
        end
        checks++;
        if (!drained()) begin
            failures++;
            $display("FAIL %s_drain: sources still pending after %0d cycles, required empty", name, budget);
        end
        repeat (FRAME + START_TO + 6) @(posedge sys_clk);
        #3;
    endtask

    // Monitor, stub uart_tx and producer model. Sampling happens on the falling edge.
    // Inputs update 1 time unit after the rising edge.
    initial begin
        logic [NUM_REQ-1:0] hit;
        bit                 start_busy;
        forever begin
            @(negedge sys_clk);
            hit        = '0;
            start_busy = 1'b0;
            if (!sys_rst) begin
                if ($countones(req_ready) > 1) multi_ready++;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        hit[i] = 1'b1;
                        acc_id.push_back(i);
                        acc_cyc.push_back(cyc);
                        acc_data.push_back(req_data[8*i +: 8]);
                    end
                end
                if (tx_en) begin
                    tx_log.push_back(tx_din);
                    tx_cyc.push_back(cyc);
                    start_busy = stub_on;
                end
                if (tx_err) err_cyc.push_back(cyc);
            end
            @(posedge sys_clk);
            cyc++;
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hit[i]) src_pos[i]++;
            end
            if (start_busy) begin
                tx_busy  = 1'b1;
                busy_cnt = FRAME;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
            drive();
        end
    end

    task automatic test_reset();
        do_reset();
        clear_all();
        @(negedge sys_clk);
        checks += 6;
        if (tx_en !== 1'b0)        begin failures++; $display("FAIL rst_tx_en: got %b expected 0", tx_en); end
        if (tx_din !== 8'h00)      begin failures++; $display("FAIL rst_tx_din: got %h expected 00", tx_din); end
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        if (grant_id !== 2'd0)     begin failures++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
        if (grant_active !== 1'b0) begin failures++; $display("FAIL rst_grant_active: got %b expected 0", grant_active); end
        if (tx_err !== 1'b0)       begin failures++; $display("FAIL rst_tx_err: got %b expected 0", tx_err); end
    endtask

    task automatic test_single();
        do_reset();
        clear_all();
        put(0, 8'hA5, 1'b1);
        drive();
        wait_drained("single", 60);
        checks++;
        if (acc_id.size() != 1 || tx_log.size() != 1) begin
            failures++;
            $display("FAIL single_count: got %0d accepts %0d tx expected 1 1", acc_id.size(), tx_log.size());
        end else begin
            checks += 3;
            if (acc_id[0] !== 0) begin failures++; $display("FAIL single_id: got %0d expected 0", acc_id[0]); end
            if (tx_log[0] !== 8'hA5) begin failures++; $display("FAIL single_byte: got %h expected a5", tx_log[0]); end
            if (tx_cyc[0] - acc_cyc[0] !== 1) begin
                failures++; $display("FAIL single_latency: got %0d expected 1", tx_cyc[0] - acc_cyc[0]);
            end
        end
        @(negedge sys_clk);
        checks += 3;
        if (tx_din !== 8'hA5) begin failures++; $display("FAIL single_hold: got %h expected a5", tx_din); end
        if (tx_en !== 1'b0)   begin failures++; $display("FAIL single_tx_en_idle: got %b expected 0", tx_en); end
        if (err_cyc.size() != 0) begin failures++; $display("FAIL single_err: got %0d expected 0", err_cyc.size()); end
    endtask

    task automatic test_round_robin();
        int         exp_id[4];
        logic [7:0] exp_d[4];
        exp_id = '{0, 1, 2, 0};
        exp_d  = '{8'h10, 8'h11, 8'h12, 8'h13};
        do_reset();
        clear_all();
        put(0, 8'h10, 1'b1); put(0, 8'h13, 1'b1);
        put(1, 8'h11, 1'b1); put(2, 8'h12, 1'b1);
        drive();
        wait_drained("rr", 150);
        checks++;
        if (acc_id.size() != 4 || tx_log.size() != 4) begin
            failures++;
            $display("FAIL rr_count: got %0d accepts %0d tx expected 4 4", acc_id.size(), tx_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (acc_id[k] !== exp_id[k] || tx_log[k] !== exp_d[k]) begin
                    failures++;
                    $display("FAIL rr_seq[%0d]: got id=%0d tx=%h expected id=%0d tx=%h", k, acc_id[k], tx_log[k], exp_id[k], exp_d[k]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (acc_cyc[k+1] - acc_cyc[k] !== FRAME + 3) begin
                    failures++;
                    $display("FAIL rr_gap[%0d]: got %0d expected %0d", k, acc_cyc[k+1] - acc_cyc[k], FRAME + 3);
                end
            end
        end
        checks++;
        if (multi_ready !== 0) begin failures++; $display("FAIL rr_onehot: got %0d multi-ready cycles expected 0", multi_ready); end
    endtask

    task automatic test_packet_lock();
        int         exp_id[6];
        logic [7:0] exp_d[6];
        exp_id = '{0, 1, 1, 1, 2, 0};
        exp_d  = '{8'h50, 8'h11, 8'h22, 8'h33, 8'h77, 8'h55};
        do_reset();
        clear_all();
        put(0, 8'h50, 1'b1); put(0, 8'h55, 1'b1);
        put(1, 8'h11, 1'b0); put(1, 8'h22, 1'b0); put(1, 8'h33, 1'b1);
        put(2, 8'h77, 1'b1);
        drive();
        wait_drained("lock", 200);
        checks++;
        if (acc_id.size() != 6 || tx_log.size() != 6) begin
            failures++;
            $display("FAIL lock_count: got %0d accepts %0d tx expected 6 6", acc_id.size(), tx_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (acc_id[k] !== exp_id[k] || tx_log[k] !== exp_d[k]) begin
                    failures++;
                    $display("FAIL lock_seq[%0d]: got id=%0d tx=%h expected id=%0d tx=%h", k, acc_id[k], tx_log[k], exp_id[k], exp_d[k]);
                end
            end
        end
        checks++;
        if (multi_ready !== 0) begin failures++; $display("FAIL lock_onehot: got %0d multi-ready cycles expected 0", multi_ready); end
    endtask

    task automatic test_burst_limit();
        int         exp_id[9];
        logic [7:0] exp_d[9];
        exp_id = '{2, 2, 2, 3, 2, 2, 2, 3, 2};
        exp_d  = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h23, 8'h24, 8'h25, 8'h31, 8'h26};
        do_reset();
        clear_all();
        for (int b = 0; b < 7; b++) put(2, 8'(8'h20 + b), 1'b0);
        put(3, 8'h30, 1'b1); put(3, 8'h31, 1'b1);
        drive();
        wait_drained("burst", 300);
        checks++;
        if (acc_id.size() != 9 || tx_log.size() != 9) begin
            failures++;
            $display("FAIL burst_count: got %0d accepts %0d tx expected 9 9", acc_id.size(), tx_log.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (acc_id[k] !== exp_id[k] || tx_log[k] !== exp_d[k]) begin
                    failures++;
                    $display("FAIL burst_seq[%0d]: got id=%0d tx=%h expected id=%0d tx=%h", k, acc_id[k], tx_log[k], exp_id[k], exp_d[k]);
                end
            end
        end
        // req2 stopped offering bytes while still locked, so the lock must have been dropped.
        @(negedge sys_clk);
        checks += 2;
        if (grant_active !== 1'b0) begin failures++; $display("FAIL burst_drop_lock: got %b expected 0", grant_active); end
        if (grant_id !== 2'd2)     begin failures++; $display("FAIL burst_last_grant: got %0d expected 2", grant_id); end
    endtask

    task automatic test_timeout();
        int         exp_id[3];
        logic [7:0] exp_d[3];
        exp_id = '{0, 1, 0};
        exp_d  = '{8'h3C, 8'h4D, 8'h3D};
        do_reset();
        clear_all();
        stub_on = 1'b0;
        put(0, 8'h3C, 1'b0); put(0, 8'h3D, 1'b1);
        put(1, 8'h4D, 1'b1);
        drive();
        wait_drained("timeout", 100);
        stub_on = 1'b1;
        checks++;
        if (acc_id.size() != 3 || tx_log.size() != 3 || err_cyc.size() != 3) begin
            failures++;
            $display("FAIL to_count: got %0d accepts %0d tx %0d errs expected 3 3 3", acc_id.size(), tx_log.size(), err_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks += 2;
                if (acc_id[k] !== exp_id[k] || tx_log[k] !== exp_d[k]) begin
                    failures++;
                    $display("FAIL to_seq[%0d]: got id=%0d tx=%h expected id=%0d tx=%h", k, acc_id[k], tx_log[k], exp_id[k], exp_d[k]);
                end
                if (err_cyc[k] - tx_cyc[k] !== START_TO) begin
                    failures++;
                    $display("FAIL to_delay[%0d]: got %0d expected %0d", k, err_cyc[k] - tx_cyc[k], START_TO);
                end
            end
            checks++;
            if (acc_cyc[1] !== err_cyc[0]) begin
                failures++;
                $display("FAIL to_rearb: got accept at %0d expected %0d", acc_cyc[1], err_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        do_reset();
        clear_all();
        put(0, 8'h81, 1'b1); put(1, 8'h92, 1'b1);
        drive();
        while (tx_log.size() < 1 && n < 40) begin
            @(posedge sys_clk); #3;
            n++;
        end
        repeat (2) @(posedge sys_clk);
        #3;
        do_reset();
        @(negedge sys_clk);
        checks += 6;
        if (tx_en !== 1'b0)        begin failures++; $display("FAIL mid_tx_en: got %b expected 0", tx_en); end
        if (tx_din !== 8'h00)      begin failures++; $display("FAIL mid_tx_din: got %h expected 00", tx_din); end
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
        if (grant_id !== 2'd0)     begin failures++; $display("FAIL mid_grant_id: got %0d expected 0", grant_id); end
        if (grant_active !== 1'b0) begin failures++; $display("FAIL mid_grant_active: got %b expected 0", grant_active); end
        if (tx_err !== 1'b0)       begin failures++; $display("FAIL mid_tx_err: got %b expected 0", tx_err); end
        wait_drained("mid", 60);
        checks++;
        if (acc_id.size() != 2 || tx_log.size() != 2) begin
            failures++;
            $display("FAIL mid_count: got %0d accepts %0d tx expected 2 2", acc_id.size(), tx_log.size());
        end else begin
            checks += 2;
            if (acc_id[1] !== 1 || tx_log[1] !== 8'h92) begin
                failures++;
                $display("FAIL mid_second: got id=%0d tx=%h expected id=1 tx=92", acc_id[1], tx_log[1]);
            end
            if (acc_cyc[1] - acc_cyc[0] !== FRAME + 2) begin
                failures++;
                $display("FAIL mid_wait_busy: got gap %0d expected %0d", acc_cyc[1] - acc_cyc[0], FRAME + 2);
            end
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        tx_busy   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_burst_limit();
        test_timeout();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
